// File: rtl/bp_pkg.sv
// Shared parameters, state encoding and helpers for the branch resolve unit.
package bp_pkg;

    localparam int unsigned LOWER_DEF        = 5;
    localparam int unsigned DEPTH_DEF        = 4;
    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned CNT_W            = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Saturating increment for the mispredict counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Synchronous FIFO of outstanding predictions with a single-cycle clear.
module pred_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Extra pointer MSB separates the full and empty cases when indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches resolved branches against queued predictions, updates the history
// table and squashes the younger pipeline on a mispredict.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned LOWER        = LOWER_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [LOWER-1:0] pred_addr,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             res_jumped,
    output logic             res_ready,
    output logic             bht_en,
    output logic [LOWER-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             bht_jumped,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             underflow_err
);

    localparam int unsigned EW = LOWER + 1;
    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    fcnt;
    logic [CW-1:0]    fcnt_d;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             mispredict;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] miss_cnt_d;

    // Handshakes are combinational so a pop can free a full slot in the same cycle.
    assign res_ready  = !rst && (state == RUN) && !empty;
    assign pred_ready = !rst && (state == RUN) && (!full || pop);
    assign pop        = res_valid && res_ready;
    assign push       = pred_valid && pred_ready;
    assign wdata      = {pred_addr, pred_taken};
    assign mispredict = pop && ((res_taken || res_jumped) != rdata[0]);

    assign mispredict_count = miss_cnt;
    assign miss_cnt_d       = mispredict ? sat_inc(miss_cnt) : miss_cnt;

    // A mispredict squashes every younger prediction still queued.
    pred_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (mispredict),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_d;
            fcnt  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
            end
            FLUSH: begin
                if (fcnt == CW'(FLUSH_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt + CW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Registered outputs: flush tracks the FLUSH state, table update trails the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush          <= 1'b0;
            miss_cnt       <= '0;
            underflow_err  <= 1'b0;
            bht_en         <= 1'b0;
            bht_write_addr <= '0;
            bht_was_taken  <= 1'b0;
            bht_jumped     <= 1'b0;
        end else begin
            flush    <= (state_d == FLUSH);
            miss_cnt <= miss_cnt_d;
            bht_en   <= pop;
            if (res_valid && empty && (state == RUN)) begin
                underflow_err <= 1'b1;
            end
            if (pop) begin
                bht_write_addr <= rdata[EW-1:1];
                bht_was_taken  <= res_taken;
                bht_jumped     <= res_jumped;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a prediction-queue model and a
// scoreboard of expected history-table updates.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [4:0]  pred_addr;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        res_jumped;
    logic        res_ready;
    logic        bht_en;
    logic [4:0]  bht_write_addr;
    logic        bht_was_taken;
    logic        bht_jumped;
    logic        flush;
    logic [15:0] mispredict_count;
    logic        underflow_err;

    typedef struct packed {
        logic [4:0] addr;
        logic       taken;
        logic       jumped;
    } upd_t;

    typedef struct packed {
        logic [4:0] addr;
        logic       pred;
    } ent_t;

    upd_t        exp_q[$];
    ent_t        model_q[$];
    logic [15:0] exp_cnt;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_addr        (pred_addr),
        .pred_taken       (pred_taken),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_jumped       (res_jumped),
        .res_ready        (res_ready),
        .bht_en           (bht_en),
        .bht_write_addr   (bht_write_addr),
        .bht_was_taken    (bht_was_taken),
        .bht_jumped       (bht_jumped),
        .flush            (flush),
        .mispredict_count (mispredict_count),
        .underflow_err    (underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge, then check the table-update port against the scoreboard.
    task automatic tick();
        upd_t e;
        @(posedge clk);
        #1;
        chk("bht_en", 32'(bht_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (bht_en) begin
                chk("bht_write_addr", 32'(bht_write_addr), 32'(e.addr));
                chk("bht_was_taken", 32'(bht_was_taken), 32'(e.taken));
                chk("bht_jumped", 32'(bht_jumped), 32'(e.jumped));
            end
        end
    endtask

    task automatic push_pred(input logic [4:0] a, input logic p);
        pred_valid = 1'b1;
        pred_addr  = a;
        pred_taken = p;
        model_q.push_back('{addr: a, pred: p});
        tick();
        pred_valid = 1'b0;
    endtask

    // Resolve the oldest queued branch; expectations come from the queue model.
    task automatic resolve(input logic t, input logic j);
        ent_t h;
        res_valid  = 1'b1;
        res_taken  = t;
        res_jumped = j;
        #1;
        chk("res_ready_before_pop", 32'(res_ready), 32'd1);
        h = model_q.pop_front();
        exp_q.push_back('{addr: h.addr, taken: t, jumped: j});
        if ((t | j) != h.pred) begin
            model_q.delete();
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        tick();
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        res_jumped = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_bht_en", 32'(bht_en), 32'd0);
        chk("rst_bht_addr", 32'(bht_write_addr), 32'd0);
        chk("rst_bht_was_taken", 32'(bht_was_taken), 32'd0);
        chk("rst_bht_jumped", 32'(bht_jumped), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_count", 32'(mispredict_count), 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_addr  = '0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        res_jumped = 1'b0;
        exp_cnt    = 16'd0;

        // Reset values
        #1;
        chk("rst_pred_ready", 32'(pred_ready), 32'd0);
        tick();
        tick();
        chk_reset_outputs();
        chk("rst_pred_ready_held", 32'(pred_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("pred_ready_after_rst", 32'(pred_ready), 32'd1);

        // Correct taken prediction
        push_pred(5'd5, 1'b1);
        resolve(1'b1, 1'b0);
        chk("t1_flush", 32'(flush), 32'd0);
        chk("t1_count", 32'(mispredict_count), 32'(exp_cnt));

        // Unconditional jump counts as taken
        push_pred(5'd7, 1'b1);
        resolve(1'b0, 1'b1);
        chk("jump_flush", 32'(flush), 32'd0);

        // Mispredict: two-cycle flush, queue emptied
        push_pred(5'd3, 1'b0);
        push_pred(5'd9, 1'b1);
        resolve(1'b1, 1'b0);
        chk("t2_flush_c1", 32'(flush), 32'd1);
        chk("t2_pred_ready_c1", 32'(pred_ready), 32'd0);
        chk("t2_res_ready_c1", 32'(res_ready), 32'd0);
        tick();
        chk("t2_flush_c2", 32'(flush), 32'd1);
        chk("t2_pred_ready_c2", 32'(pred_ready), 32'd0);
        tick();
        chk("t2_flush_end", 32'(flush), 32'd0);
        chk("t2_count", 32'(mispredict_count), 32'(exp_cnt));
        chk("t2_empty", 32'(res_ready), 32'd0);
        chk("t2_pred_ready_back", 32'(pred_ready), 32'd1);

        // Fill to DEPTH, then simultaneous push and pop at full
        push_pred(5'd10, 1'b0);
        push_pred(5'd11, 1'b1);
        push_pred(5'd12, 1'b0);
        push_pred(5'd13, 1'b1);
        #1;
        chk("full_pred_ready", 32'(pred_ready), 32'd0);
        pred_valid = 1'b1;
        pred_addr  = 5'd20;
        pred_taken = 1'b1;
        model_q.push_back('{addr: 5'd20, pred: 1'b1});
        resolve(1'b0, 1'b0);
        pred_valid = 1'b0;
        #1;
        chk("full_after_pushpop", 32'(pred_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            resolve(model_q[0].pred, 1'b0);
        end
        chk("drained_res_ready", 32'(res_ready), 32'd0);
        chk("drained_flush", 32'(flush), 32'd0);

        // Resolution with an empty queue
        res_valid = 1'b1;
        res_taken = 1'b1;
        #1;
        chk("uf_res_ready", 32'(res_ready), 32'd0);
        tick();
        res_valid = 1'b0;
        res_taken = 1'b0;
        chk("uf_set", 32'(underflow_err), 32'd1);
        tick();
        push_pred(5'd2, 1'b0);
        resolve(1'b0, 1'b0);
        chk("uf_sticky", 32'(underflow_err), 32'd1);

        // Reset during the first flush cycle
        push_pred(5'd4, 1'b1);
        resolve(1'b0, 1'b0);
        chk("rf_flush_c1", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("rf_pred_ready_in_rst", 32'(pred_ready), 32'd0);
        tick();
        chk_reset_outputs();
        rst     = 1'b0;
        exp_cnt = 16'd0;
        model_q.delete();
        tick();
        chk("rf_flush_stays_low", 32'(flush), 32'd0);

        // Counter saturation from a preloaded value
        force dut.miss_cnt = 16'hFFFE;
        tick();
        release dut.miss_cnt;
        exp_cnt = 16'hFFFE;
        #1;
        chk("sat_preload", 32'(mispredict_count), 32'(exp_cnt));
        for (int k = 0; k < 3; k++) begin
            push_pred(5'(k + 24), 1'b0);
            resolve(1'b1, 1'b0);
            tick();
            tick();
            chk("sat_count", 32'(mispredict_count), 32'(exp_cnt));
        end
        chk("sat_final", 32'(mispredict_count), 32'h0000FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter LOWER, default 5, meaning PC index bits matching the branch history table.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of outstanding predictions held (power of two, >=2).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning the length of the flush pulse in cycles (>=1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, with synchronous active-high reset.
REQ-006 SHALL have port pred_valid, input, 1 bit, meaning fetch presents a predicted branch.
REQ-007 SHALL have port pred_addr, input, LOWER bits, meaning the branch PC index.
REQ-008 SHALL have port pred_taken, input, 1 bit, meaning the prediction issued by the history table.
REQ-009 SHALL have port pred_ready, output, 1 bit, meaning the queue accepts a prediction.
REQ-010 SHALL have port res_valid, input, 1 bit, meaning execute presents the resolved oldest branch.
REQ-011 SHALL have port res_taken, input, 1 bit, meaning the conditional branch was taken.
REQ-012 SHALL have port res_jumped, input, 1 bit, meaning an unconditional jump.
REQ-013 SHALL have port res_ready, output, 1 bit, meaning the resolution is accepted.
REQ-014 SHALL have port bht_en, output, 1 bit, meaning the table update strobe.
REQ-015 SHALL have port bht_write_addr, output, LOWER bits, meaning the table index to update.
REQ-016 SHALL have port bht_was_taken, output, 1 bit, carrying the table update outcome.
REQ-017 SHALL have port bht_jumped, output, 1 bit, carrying the table update jump flag.
REQ-018 SHALL have port flush, output, 1 bit, meaning squash the younger pipeline on mispredict.
REQ-019 SHALL have port mispredict_count, output, 16 bits, a saturating mispredict counter.
REQ-020 SHALL have port underflow_err, output, 1 bit, a sticky flag for resolution received with an empty queue.

Function
REQ-021 SHALL implement a FIFO of DEPTH entries {addr, pred_taken}; push on pred_valid&&pred_ready, pop on res_valid&&res_ready.
REQ-022 SHALL drive pred_ready = (state==RUN) && (not full || pop this cycle); simultaneous push and pop at full is allowed and occupancy is unchanged.
REQ-023 SHALL drive res_ready = (state==RUN) && not empty.
REQ-024 SHALL set underflow_err on res_valid with an empty queue in RUN; the resolution is ignored and the flag stays set until rst.
REQ-025 SHALL compute actual = res_taken|res_jumped and mispredict = actual != popped pred_taken.
REQ-026 SHALL, one cycle after every accepted resolution, pulse bht_en for one cycle with bht_write_addr = popped addr, bht_was_taken = res_taken, bht_jumped = res_jumped.
REQ-027 SHALL implement states RUN and FLUSH; RUN->FLUSH on an accepted mispredicting resolution; FLUSH->RUN after FLUSH_CYCLES cycles.
REQ-028 SHALL assert flush exactly for the FLUSH_CYCLES cycles in FLUSH, starting the cycle after the mispredicting pop.
REQ-029 SHALL clear all FIFO entries and pointers on entry to FLUSH; pred_ready=0 and res_ready=0 throughout FLUSH.
REQ-030 SHALL increment mispredict_count by one per mispredict and hold at 16'hFFFF.
REQ-031 SHALL wrap FIFO pointers modulo DEPTH, using an extra MSB to distinguish full from empty.

Reset
REQ-032 SHALL, on rst high at a clock edge, enter RUN with an empty FIFO and drive pred_ready=0 (during rst), res_ready=0, bht_en=0, bht_write_addr=0, bht_was_taken=0, bht_jumped=0, flush=0, mispredict_count=0, underflow_err=0.
REQ-033 SHALL let rst asserted mid-FLUSH abort the flush on that edge, with flush low the next cycle.

Structure
REQ-034 SHALL place LOWER, DEPTH and FLUSH_CYCLES defaults and the RUN/FLUSH state encoding in shared package bp_pkg.
REQ-035 SHALL instantiate the queue as sub-module pred_fifo (synchronous FIFO with clear input).

Verification
REQ-036 SHALL verify: push addr 5/pred 1, resolve taken=1 -> next cycle bht_en=1, bht_write_addr=5, bht_was_taken=1, flush=0.
REQ-037 SHALL verify: push addr 3/pred 0, resolve taken=1 -> flush high 2 cycles, FIFO empty, mispredict_count=1, pred_ready=0 during flush.
REQ-038 SHALL verify: 4 pushes with no pops -> pred_ready=0; push+pop in the same cycle -> accepted, occupancy stays 4.
REQ-039 SHALL verify: res_valid with an empty queue -> res_ready=0, underflow_err=1 and it stays 1, no bht_en.
REQ-040 SHALL verify: rst during the first flush cycle -> flush=0 the next cycle, all outputs at reset values.
REQ-041 SHALL verify: preload mispredict_count=16'hFFFE, then 3 mispredicts -> count ends at 16'hFFFF.
